// File: rtl/fetch_decode_if.sv
// Fetch/decode bus: ROM port, execute-side flag, decoded instruction fields and status.
interface fetch_decode_if #(
   parameter int unsigned IWIDTH     = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned PC_WIDTH   = 6
);
   localparam int unsigned PDW = 3 * IWIDTH + ADDR_WIDTH + 8;

   logic                  run;
   logic [PC_WIDTH-1:0]   prog_addr;
   logic [PDW-1:0]        prog_data;
   logic                  zero_flag;
   logic [IWIDTH-1:0]     op_code;
   logic [IWIDTH-1:0]     source1;
   logic [IWIDTH-1:0]     source2;
   logic [1:0]            source1_choice;
   logic [1:0]            source2_choice;
   logic [ADDR_WIDTH-1:0] destination;
   logic [1:0]            dest_choice;
   logic                  push;
   logic                  pop;
   logic [PC_WIDTH-1:0]   instr_addr;
   logic                  halted;
   logic                  stack_err;

   // Sequencer side
   modport master (
      input  run, prog_data, zero_flag,
      output prog_addr, op_code, source1, source2, source1_choice, source2_choice,
             destination, dest_choice, push, pop, instr_addr, halted, stack_err
   );

   // Environment side: ROM, datapath, register file
   modport slave (
      output run, prog_data, zero_flag,
      input  prog_addr, op_code, source1, source2, source1_choice, source2_choice,
             destination, dest_choice, push, pop, instr_addr, halted, stack_err
   );
endinterface

// File: rtl/fetch_decode.sv
// Instruction sequencer: two-cycle fetch/execute, jumps, calls with a small return stack.
module fetch_decode #(
   parameter int unsigned IWIDTH     = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned PC_WIDTH   = 6,
   parameter int unsigned RS_DEPTH   = 4
) (
   input  logic              clk,
   input  logic              rst,
   fetch_decode_if.master    bus
);
   localparam int unsigned PDW = 3 * IWIDTH + ADDR_WIDTH + 8;
   localparam int unsigned CW  = $clog2(RS_DEPTH + 1);
   localparam int unsigned IW  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [PC_WIDTH-1:0]   w_pc_nxt;
   logic [PC_WIDTH-1:0]   r_rs [RS_DEPTH];
   logic [CW-1:0]         r_rs_cnt;
   logic                  r_stack_err;
   logic                  w_rs_push;
   logic                  w_rs_pop;
   logic                  w_err_set;

   logic [IWIDTH-1:0]     w_op;
   logic [IWIDTH-1:0]     w_s1;
   logic [IWIDTH-1:0]     w_s2;
   logic [ADDR_WIDTH-1:0] w_dst;
   logic [1:0]            w_s1c;
   logic [1:0]            w_s2c;
   logic [1:0]            w_dc;
   logic [1:0]            w_cls;
   logic                  w_is_halt;
   logic [PC_WIDTH-1:0]   w_pc_inc;
   logic [PC_WIDTH-1:0]   w_target;
   logic [PC_WIDTH-1:0]   w_rs_top;
   logic                  w_rs_full;
   logic                  w_rs_empty;

   // Instruction word fields, MSB first
   assign w_op  = bus.prog_data[PDW-1 -: IWIDTH];
   assign w_s1  = bus.prog_data[PDW-1-IWIDTH -: IWIDTH];
   assign w_s2  = bus.prog_data[PDW-1-2*IWIDTH -: IWIDTH];
   assign w_dst = bus.prog_data[7+ADDR_WIDTH -: ADDR_WIDTH];
   assign w_s1c = bus.prog_data[7:6];
   assign w_s2c = bus.prog_data[5:4];
   assign w_dc  = bus.prog_data[3:2];
   assign w_cls = bus.prog_data[1:0];

   assign w_is_halt  = (w_cls == 2'b00) && (&w_op);
   assign w_pc_inc   = r_pc + PC_WIDTH'(1);
   assign w_target   = w_dst[PC_WIDTH-1:0];
   assign w_rs_full  = (r_rs_cnt == CW'(RS_DEPTH));
   assign w_rs_empty = (r_rs_cnt == '0);
   assign w_rs_top   = r_rs[IW'(r_rs_cnt - CW'(1))];

   assign bus.prog_addr = r_pc;
   assign bus.halted    = (r_state == S_HALT);
   assign bus.stack_err = r_stack_err;

   // Next state, next pc, stack control and decoded outputs
   always_comb begin
      w_state_nxt        = r_state;
      w_pc_nxt           = r_pc;
      w_rs_push          = 1'b0;
      w_rs_pop           = 1'b0;
      w_err_set          = 1'b0;
      bus.op_code        = '0;
      bus.source1        = '0;
      bus.source2        = '0;
      bus.source1_choice = 2'b00;
      bus.source2_choice = 2'b00;
      bus.destination    = '0;
      bus.dest_choice    = 2'b11;
      bus.push           = 1'b0;
      bus.pop            = 1'b0;
      bus.instr_addr     = '0;
      case (r_state)
         S_IDLE:  if (bus.run) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_EXEC;
         S_EXEC: begin
            bus.op_code        = w_op;
            bus.source1        = w_s1;
            bus.source2        = w_s2;
            bus.source1_choice = w_s1c;
            bus.source2_choice = w_s2c;
            bus.destination    = w_dst;
            bus.instr_addr     = r_pc;
            w_state_nxt        = bus.run ? S_FETCH : S_IDLE;
            w_pc_nxt           = w_pc_inc;
            case (w_cls)
               2'b00: begin
                  if (w_is_halt) begin
                     w_state_nxt = S_HALT;
                     w_pc_nxt    = r_pc;
                  end else begin
                     bus.dest_choice = w_dc;
                  end
               end
               2'b01: w_pc_nxt = w_target;
               2'b10: if (bus.zero_flag) w_pc_nxt = w_target;
               default: begin
                  case (w_op[1:0])
                     2'b00: bus.push = 1'b1;
                     2'b01: bus.pop  = 1'b1;
                     2'b10: begin
                        if (!w_rs_full) begin
                           w_rs_push = 1'b1;
                           w_pc_nxt  = w_target;
                        end else begin
                           w_err_set = 1'b1;
                        end
                     end
                     default: begin
                        if (!w_rs_empty) begin
                           w_rs_pop = 1'b1;
                           w_pc_nxt = w_rs_top;
                        end else begin
                           w_err_set = 1'b1;
                        end
                     end
                  endcase
               end
            endcase
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, pc, stack depth and sticky error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_rs_cnt    <= '0;
         r_stack_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_rs_push)     r_rs_cnt <= r_rs_cnt + CW'(1);
         else if (w_rs_pop) r_rs_cnt <= r_rs_cnt - CW'(1);
         if (w_err_set) r_stack_err <= 1'b1;
      end
   end

   // Return address storage; emptiness is tracked by r_rs_cnt alone
   always_ff @(posedge clk) begin
      if (!rst && w_rs_push) r_rs[IW'(r_rs_cnt)] <= w_pc_inc;
   end
endmodule
